// File: rtl/if_id_stage.sv
// IF/ID pipeline register with instruction field decode, load-use stall and
// branch/jump flush control, plus saturating stall/flush event counters.
module if_id_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] if_instr,
    input  logic [15:0] if_pc_inc,
    input  logic        idex_mem_read,
    input  logic        idex_valid,
    input  logic [3:0]  idex_rt,
    input  logic        ex_branch_taken,
    output logic [15:0] id_instr,
    output logic [15:0] id_pc_inc,
    output logic        id_valid,
    output logic [3:0]  id_op,
    output logic [3:0]  id_rs,
    output logic [3:0]  id_rt,
    output logic [3:0]  id_rd,
    output logic [15:0] id_offset,
    output logic [15:0] id_jaddr,
    output logic        pc_write,
    output logic [1:0]  pc_sel,
    output logic        idex_bubble,
    output logic [7:0]  stall_cnt,
    output logic [7:0]  flush_cnt
);

    localparam logic [3:0] OP_R    = 4'b0000;
    localparam logic [3:0] OP_LW   = 4'b0001;
    localparam logic [3:0] OP_SW   = 4'b0010;
    localparam logic [3:0] OP_BNE  = 4'b0011;
    localparam logic [3:0] OP_ADDI = 4'b0100;
    localparam logic [3:0] OP_J    = 4'b0101;

    localparam logic [1:0] SEL_INC    = 2'b00;
    localparam logic [1:0] SEL_BRANCH = 2'b01;
    localparam logic [1:0] SEL_JUMP   = 2'b10;

    typedef enum logic [1:0] {
        ACT_LOAD,
        ACT_HOLD,
        ACT_FLUSH
    } act_t;

    act_t act;
    logic rs_src;
    logic rt_src;
    logic load_use;
    logic jump;
    logic pc_write_raw;
    logic bubble_raw;
    logic [1:0] pc_sel_raw;

    assign id_op     = id_instr[15:12];
    assign id_rs     = id_instr[11:8];
    assign id_rt     = id_instr[7:4];
    assign id_rd     = id_instr[3:0];
    assign id_offset = {{12{id_instr[3]}}, id_instr[3:0]};
    assign id_jaddr  = {id_pc_inc[15:12], id_instr[11:0]};

    always_comb begin
        rs_src = 1'b0;
        rt_src = 1'b0;
        case (id_op)
            OP_R, OP_SW, OP_BNE: begin
                rs_src = 1'b1;
                rt_src = 1'b1;
            end
            OP_LW, OP_ADDI: rs_src = 1'b1;
            default: ;
        endcase
    end

    assign load_use = idex_valid & idex_mem_read & id_valid & (idex_rt != 4'd0) &
                      ((rs_src & (idex_rt == id_rs)) | (rt_src & (idex_rt == id_rt)));
    assign jump     = id_valid & (id_op == OP_J);

    // Branch beats load-use beats jump; a jump flush needs no ID/EX bubble.
    always_comb begin
        act          = ACT_LOAD;
        pc_write_raw = 1'b1;
        pc_sel_raw   = SEL_INC;
        bubble_raw   = 1'b0;
        if (ex_branch_taken) begin
            act        = ACT_FLUSH;
            pc_sel_raw = SEL_BRANCH;
            bubble_raw = 1'b1;
        end else if (load_use) begin
            act          = ACT_HOLD;
            pc_write_raw = 1'b0;
            bubble_raw   = 1'b1;
        end else if (jump) begin
            act        = ACT_FLUSH;
            pc_sel_raw = SEL_JUMP;
        end
    end

    // Control outputs read as normal-advance while reset is held.
    assign pc_write    = reset ? pc_write_raw : 1'b1;
    assign pc_sel      = reset ? pc_sel_raw : SEL_INC;
    assign idex_bubble = reset ? bubble_raw : 1'b0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_instr  <= 16'h0000;
            id_pc_inc <= 16'h0000;
            id_valid  <= 1'b0;
            stall_cnt <= 8'h00;
            flush_cnt <= 8'h00;
        end else begin
            case (act)
                ACT_FLUSH: begin
                    id_instr  <= 16'h0000;
                    id_pc_inc <= 16'h0000;
                    id_valid  <= 1'b0;
                    if (flush_cnt != 8'hFF)
                        flush_cnt <= flush_cnt + 8'd1;
                end
                ACT_HOLD: begin
                    if (stall_cnt != 8'hFF)
                        stall_cnt <= stall_cnt + 8'd1;
                end
                default: begin
                    id_instr  <= if_instr;
                    id_pc_inc <= if_pc_inc;
                    id_valid  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_id_stage.sv
// Randomized bench for if_id_stage against a behavioural IF/ID model with
// directed cases for decode, stall, flush, jump and counter saturation.
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] if_instr, if_pc_inc;
    logic        idex_mem_read, idex_valid, ex_branch_taken;
    logic [3:0]  idex_rt;
    logic [15:0] id_instr, id_pc_inc, id_offset, id_jaddr;
    logic        id_valid, pc_write, idex_bubble;
    logic [3:0]  id_op, id_rs, id_rt, id_rd;
    logic [1:0]  pc_sel;
    logic [7:0]  stall_cnt, flush_cnt;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [15:0] m_instr, m_pc;
    logic        m_valid;
    int          m_stall, m_flush;
    bit          rs_uses[16];
    bit          rt_uses[16];
    int          ev;          // 0 load, 1 hold, 2 flush, 3 reset
    logic [1:0]  e_sel;
    logic        e_pw, e_bub;

    if_id_stage dut (
        .clk(clk), .reset(reset), .if_instr(if_instr), .if_pc_inc(if_pc_inc),
        .idex_mem_read(idex_mem_read), .idex_valid(idex_valid), .idex_rt(idex_rt),
        .ex_branch_taken(ex_branch_taken), .id_instr(id_instr), .id_pc_inc(id_pc_inc),
        .id_valid(id_valid), .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_offset(id_offset), .id_jaddr(id_jaddr), .pc_write(pc_write), .pc_sel(pc_sel),
        .idex_bubble(idex_bubble), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic compare_all();
        int op, imm;
        logic [15:0] off;
        op  = int'(m_instr) / 4096;
        imm = int'(m_instr) % 16;
        off = (imm >= 8) ? 16'(imm + 65520) : 16'(imm);
        chk("id_instr",  id_instr, m_instr);
        chk("id_pc_inc", id_pc_inc, m_pc);
        chk("id_valid",  16'(id_valid), 16'(m_valid));
        chk("id_op",     16'(id_op), 16'(op));
        chk("id_rs",     16'(id_rs), 16'((int'(m_instr) / 256) % 16));
        chk("id_rt",     16'(id_rt), 16'((int'(m_instr) / 16) % 16));
        chk("id_rd",     16'(id_rd), 16'(imm));
        chk("id_offset", id_offset, off);
        chk("id_jaddr",  id_jaddr, (m_pc & 16'hF000) | (m_instr & 16'h0FFF));
        chk("pc_sel",    16'(pc_sel), 16'(e_sel));
        chk("pc_write",  16'(pc_write), 16'(e_pw));
        chk("idex_bubble", 16'(idex_bubble), 16'(e_bub));
        chk("stall_cnt", 16'(stall_cnt), 16'(m_stall));
        chk("flush_cnt", 16'(flush_cnt), 16'(m_flush));
    endtask

    task automatic apply(input logic r, input logic [15:0] ins, input logic [15:0] pci,
                         input logic mr, input logic v, input logic [3:0] rt,
                         input logic br);
        int op, f_rs, f_rt;
        bit lu, jp;
        @(negedge clk);
        reset = r; if_instr = ins; if_pc_inc = pci;
        idex_mem_read = mr; idex_valid = v; idex_rt = rt; ex_branch_taken = br;
        if (!r) begin
            m_instr = 0; m_pc = 0; m_valid = 0; m_stall = 0; m_flush = 0;
        end
        op   = int'(m_instr) / 4096;
        f_rs = (int'(m_instr) / 256) % 16;
        f_rt = (int'(m_instr) / 16) % 16;
        lu = v && mr && m_valid && rt != 0 &&
             ((rs_uses[op] && int'(rt) == f_rs) || (rt_uses[op] && int'(rt) == f_rt));
        jp = m_valid && op == 5;
        if (!r)      begin ev = 3; e_sel = 2'd0; e_pw = 1; e_bub = 0; end
        else if (br) begin ev = 2; e_sel = 2'd1; e_pw = 1; e_bub = 1; end
        else if (lu) begin ev = 1; e_sel = 2'd0; e_pw = 0; e_bub = 1; end
        else if (jp) begin ev = 2; e_sel = 2'd2; e_pw = 1; e_bub = 0; end
        else         begin ev = 0; e_sel = 2'd0; e_pw = 1; e_bub = 0; end
        #1;
        compare_all();
    endtask

    task automatic tick();
        @(posedge clk);
        case (ev)
            0: begin m_instr = if_instr; m_pc = if_pc_inc; m_valid = 1; end
            1: m_stall = (m_stall < 255) ? m_stall + 1 : 255;
            2: begin
                m_instr = 0; m_pc = 0; m_valid = 0;
                m_flush = (m_flush < 255) ? m_flush + 1 : 255;
            end
            default: ;
        endcase
        #1;
    endtask

    initial begin
        int sv_flush, sv_stall;
        logic [15:0] ins;
        logic [3:0]  hrt;
        for (int i = 0; i < 16; i++) begin
            rs_uses[i] = (i <= 4);
            rt_uses[i] = (i == 0 || i == 2 || i == 3);
        end
        reset = 0; if_instr = 0; if_pc_inc = 0; idex_mem_read = 0;
        idex_valid = 0; idex_rt = 0; ex_branch_taken = 0;
        m_instr = 0; m_pc = 0; m_valid = 0; m_stall = 0; m_flush = 0; ev = 3;

        // reset state, including branch input asserted during reset
        apply(0, 16'h0000, 16'h0000, 0, 0, 4'd0, 1); tick();

        // first fetch after release
        apply(1, 16'h4123, 16'h0001, 0, 0, 4'd0, 0); tick();
        chk("r_first_valid", 16'(id_valid), 16'd1);
        chk("r_first_op", 16'(id_op), 16'd4);
        chk("r_first_rs", 16'(id_rs), 16'd1);
        chk("r_first_rt", 16'(id_rt), 16'd2);
        chk("r_first_off", id_offset, 16'h0003);

        // load-use on R-type rt
        apply(1, 16'h0345, 16'h0002, 0, 0, 4'd0, 0); tick();
        apply(1, 16'h1111, 16'h0003, 1, 1, 4'd4, 0);
        chk("lu_pc_write", 16'(pc_write), 16'd0);
        chk("lu_bubble", 16'(idex_bubble), 16'd1);
        tick();
        chk("lu_hold", id_instr, 16'h0345);
        chk("lu_stall_cnt", 16'(stall_cnt), 16'd1);

        // register 0 never hazards
        apply(1, 16'h0045, 16'h0003, 0, 0, 4'd0, 0); tick();
        apply(1, 16'h2222, 16'h0004, 1, 1, 4'd0, 0);
        chk("r0_pc_write", 16'(pc_write), 16'd1);
        tick();

        // branch beats simultaneous load-use
        apply(1, 16'h3128, 16'h0005, 0, 0, 4'd0, 0); tick();
        sv_flush = int'(flush_cnt); sv_stall = int'(stall_cnt);
        apply(1, 16'h7777, 16'h0006, 1, 1, 4'd2, 1);
        chk("bne_offset", id_offset, 16'hFFF8);
        chk("br_pc_sel", 16'(pc_sel), 16'd1);
        chk("br_pc_write", 16'(pc_write), 16'd1);
        tick();
        chk("br_valid", 16'(id_valid), 16'd0);
        chk("br_flush_cnt", 16'(flush_cnt), 16'(sv_flush + 1));
        chk("br_stall_cnt", 16'(stall_cnt), 16'(sv_stall));

        // jump
        apply(1, 16'h5ABC, 16'h7001, 0, 0, 4'd0, 0); tick();
        apply(1, 16'h0000, 16'h7002, 0, 0, 4'd0, 0);
        chk("j_jaddr", id_jaddr, 16'h7ABC);
        chk("j_pc_sel", 16'(pc_sel), 16'd2);
        tick();
        chk("j_valid", 16'(id_valid), 16'd0);

        // randomized traffic with biased hazards and occasional reset
        for (int n = 0; n < 600; n++) begin
            ins = 16'($urandom);
            if ($urandom_range(0, 3) != 0) ins[15:12] = 4'($urandom_range(0, 5));
            hrt = 4'($urandom);
            if ($urandom_range(0, 1) == 1)
                hrt = ($urandom_range(0, 1) == 1) ? m_instr[11:8] : m_instr[7:4];
            apply(($urandom_range(0, 39) != 0), ins, 16'($urandom),
                  ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7), hrt,
                  ($urandom_range(0, 7) == 0));
            tick();
        end

        // counter saturation under continuous stall, then async reset
        apply(0, 16'h0000, 16'h0000, 0, 0, 4'd0, 0); tick();
        apply(1, 16'h0345, 16'h0010, 0, 0, 4'd0, 0); tick();
        for (int n = 0; n < 300; n++) begin
            apply(1, 16'($urandom), 16'($urandom), 1, 1, 4'd4, 0);
            tick();
        end
        chk("sat_stall_cnt", 16'(stall_cnt), 16'h00FF);
        chk("sat_hold", id_instr, 16'h0345);
        apply(0, 16'h1234, 16'h0020, 1, 1, 4'd4, 0);
        chk("rst_stall_cnt", 16'(stall_cnt), 16'd0);
        chk("rst_flush_cnt", 16'(flush_cnt), 16'd0);
        tick();
        apply(1, 16'h4567, 16'h0021, 1, 1, 4'd4, 0); tick();
        chk("rst_release_load", id_instr, 16'h4567);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 16-bit datapath and 4-bit register specifiers.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (reset==0 resets immediately, independent of clk).
REQ-004 if_instr  input  16  instruction fetched this cycle from instruction memory.
REQ-005 if_pc_inc  input  16  PC+1 of the fetched instruction, from the PC increment adder.
REQ-006 idex_mem_read, idex_valid  input  1 each  ID/EX holds a valid load.
REQ-007 idex_rt  input  4  destination register of the instruction in ID/EX.
REQ-008 ex_branch_taken  input  1  BNE resolved taken in EX this cycle.
REQ-009 id_instr, id_pc_inc  output  16 each  registered IF/ID contents.
REQ-010 id_valid  output  1  IF/ID holds a real instruction.
REQ-011 id_op, id_rs, id_rt, id_rd  output  4 each  fields [15:12], [11:8], [7:4], [3:0] of id_instr.
REQ-012 id_offset  output  16  id_instr[3:0] sign-extended; this drives the branch offset adder.
REQ-013 id_jaddr  output  16  {id_pc_inc[15:12], id_instr[11:0]}.
REQ-014 pc_write  output  1  0 freezes the PC register.
REQ-015 pc_sel  output  2  00 PC+1, 01 branch target, 10 jump target.
REQ-016 idex_bubble  output  1  ID/EX SHALL load a NOP this edge.
REQ-017 stall_cnt, flush_cnt  output  8 each  saturating event counters.

Function
REQ-018 Opcodes: 0000 R-type, 0001 LW, 0010 SW, 0011 BNE, 0100 ADDI, 0101 J; all other opcodes SHALL decode as NOP (no source use, no jump).
REQ-019 rs is a source for every opcode except J and NOP; rt is a source for R-type, SW, BNE only.
REQ-020 load_use = idex_valid & idex_mem_read & id_valid & idex_rt!=0 & ((rs-source & idex_rt==id_rs) | (rt-source & idex_rt==id_rt)); combinational.
REQ-021 jump = id_valid & id_op==0101; combinational.
REQ-022 Priority per cycle: ex_branch_taken > load_use > jump > normal.
REQ-023 ex_branch_taken: pc_sel=01, pc_write=1, idex_bubble=1, IF/ID loads id_valid=0 (instr/pc_inc cleared to 0), flush_cnt +1.
REQ-024 load_use (no branch): pc_write=0, pc_sel=00, idex_bubble=1, IF/ID holds all contents unchanged, stall_cnt +1.
REQ-025 jump (no branch, no load_use): pc_sel=10, pc_write=1, idex_bubble=0, IF/ID loads id_valid=0, flush_cnt +1.
REQ-026 Normal: pc_sel=00, pc_write=1, idex_bubble=0, IF/ID loads if_instr, if_pc_inc, id_valid=1.
REQ-027 A stall lasts exactly one cycle per load-use pair; the bubble in ID/EX SHALL make load_use false next cycle.
REQ-028 Counters SHALL saturate at 8'hFF, never wrap.
REQ-029 Decode outputs SHALL be combinational from the IF/ID register (zero added latency); IF-to-ID latency is one clock.
REQ-030 When id_valid=0, pc_sel/pc_write SHALL follow normal behaviour unless ex_branch_taken=1.

Reset
REQ-031 While reset==0: id_instr=0, id_pc_inc=0, id_valid=0, stall_cnt=0, flush_cnt=0; combinational outputs then read pc_write=1, pc_sel=00, idex_bubble=0.
REQ-032 Reset asserted mid-stall or mid-flush SHALL discard the pending event; the first edge after release loads if_instr normally.

Verification
REQ-033 Reset release, if_instr=16'h4123, if_pc_inc=16'h0001 -> after one edge id_valid=1, id_op=4, id_rs=1, id_rt=2, id_offset=16'h0003.
REQ-034 IF/ID=16'h0345 (R-type rs=3,rt=4), idex_valid=1, idex_mem_read=1, idex_rt=4 -> pc_write=0, idex_bubble=1, IF/ID unchanged after edge, stall_cnt=1.
REQ-035 Same as REQ-034 with idex_rt=0 and id_rs=0 -> no stall, pc_write=1.
REQ-036 IF/ID=16'h3128 (BNE, imm 8) -> id_offset=16'hFFF8; ex_branch_taken=1 with simultaneous load_use -> pc_sel=01, pc_write=1, id_valid=0 next, flush_cnt+1, stall_cnt unchanged.
REQ-037 IF/ID=16'h5ABC, id_pc_inc=16'h7001 -> id_jaddr=16'h7ABC, pc_sel=10, id_valid=0 after edge.
REQ-038 300 consecutive load-use stalls (reload hazard each cycle) -> stall_cnt holds 8'hFF; reset low mid-sequence -> all counters 0 immediately.
